// File: rtl/arith_checker.sv
// Result-side checker for an adder/multiplier pair: reference sum is combinational, reference product is iterative shift-add.
// Define ARITH_CHECKER_ERR_CAPTURE_EN to keep the operands of the first failing vector since reset.
module arith_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_op_a,
  input  logic [WIDTH-1:0]     i_op_b,
  input  logic [WIDTH:0]       i_add_result,
  input  logic [2*WIDTH-1:0]   i_mul_result,
  output logic                 o_chk_valid,
  output logic                 o_add_ok,
  output logic                 o_mul_ok,
  output logic [CNT_W-1:0]     o_pass_cnt,
  output logic [CNT_W-1:0]     o_fail_cnt,
  output logic                 o_err_valid,
  output logic [WIDTH-1:0]     o_err_op_a,
  output logic [WIDTH-1:0]     o_err_op_b
);
  localparam int ITER_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mul_res_reg, mul_res_next;
  logic                 add_ok_lat_reg, add_ok_lat_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplr_reg, mplr_next;
  logic [ITER_W-1:0]    iter_reg, iter_next;
  logic                 chk_valid_reg, chk_valid_next;
  logic                 add_ok_reg, add_ok_next;
  logic                 mul_ok_reg, mul_ok_next;
  logic [CNT_W-1:0]     pass_cnt_reg, pass_cnt_next;
  logic [CNT_W-1:0]     fail_cnt_reg, fail_cnt_next;

  logic [2*WIDTH-1:0]   acc_step;
  logic                 last_iter;
  logic                 mul_match;
  logic                 accept;

  assign acc_step  = mplr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign last_iter = (state_reg == MUL) && (iter_reg == ITER_W'(WIDTH - 1));
  assign mul_match = (acc_step == mul_res_reg);
  assign accept    = (state_reg == IDLE) && i_valid;

  always_comb begin
    state_next      = state_reg;
    mul_res_next    = mul_res_reg;
    add_ok_lat_next = add_ok_lat_reg;
    acc_next        = acc_reg;
    mcand_next      = mcand_reg;
    mplr_next       = mplr_reg;
    iter_next       = iter_reg;
    chk_valid_next  = 1'b0;
    add_ok_next     = add_ok_reg;
    mul_ok_next     = mul_ok_reg;
    pass_cnt_next   = pass_cnt_reg;
    fail_cnt_next   = fail_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          mul_res_next    = i_mul_result;
          add_ok_lat_next = (({1'b0, i_op_a} + {1'b0, i_op_b}) == i_add_result);
          acc_next        = '0;
          mcand_next      = {{WIDTH{1'b0}}, i_op_a};
          mplr_next       = i_op_b;
          iter_next       = '0;
          state_next      = MUL;
        end
      end
      MUL: begin
        // Fixed WIDTH iterations so latency never depends on operand values.
        acc_next   = acc_step;
        mcand_next = mcand_reg << 1;
        mplr_next  = mplr_reg >> 1;
        iter_next  = iter_reg + 1'b1;
        if (last_iter) begin
          mul_ok_next    = mul_match;
          add_ok_next    = add_ok_lat_reg;
          chk_valid_next = 1'b1;
          state_next     = IDLE;
          if (add_ok_lat_reg && mul_match) begin
            if (pass_cnt_reg != {CNT_W{1'b1}}) pass_cnt_next = pass_cnt_reg + 1'b1;
          end else begin
            if (fail_cnt_reg != {CNT_W{1'b1}}) fail_cnt_next = fail_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      mul_res_reg    <= '0;
      add_ok_lat_reg <= 1'b0;
      acc_reg        <= '0;
      mcand_reg      <= '0;
      mplr_reg       <= '0;
      iter_reg       <= '0;
      chk_valid_reg  <= 1'b0;
      add_ok_reg     <= 1'b0;
      mul_ok_reg     <= 1'b0;
      pass_cnt_reg   <= '0;
      fail_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      mul_res_reg    <= mul_res_next;
      add_ok_lat_reg <= add_ok_lat_next;
      acc_reg        <= acc_next;
      mcand_reg      <= mcand_next;
      mplr_reg       <= mplr_next;
      iter_reg       <= iter_next;
      chk_valid_reg  <= chk_valid_next;
      add_ok_reg     <= add_ok_next;
      mul_ok_reg     <= mul_ok_next;
      pass_cnt_reg   <= pass_cnt_next;
      fail_cnt_reg   <= fail_cnt_next;
    end
  end

`ifdef ARITH_CHECKER_ERR_CAPTURE_EN
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             err_valid_reg;
  logic [WIDTH-1:0] err_a_reg, err_b_reg;
  logic             fail_now;

  assign fail_now = last_iter && !(add_ok_lat_reg && mul_match);

  // Only the first failure since reset is kept; later ones are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      err_valid_reg <= 1'b0;
      err_a_reg     <= '0;
      err_b_reg     <= '0;
    end else begin
      if (accept) begin
        a_reg <= i_op_a;
        b_reg <= i_op_b;
      end
      if (fail_now && !err_valid_reg) begin
        err_valid_reg <= 1'b1;
        err_a_reg     <= a_reg;
        err_b_reg     <= b_reg;
      end
    end
  end

  assign o_err_valid = err_valid_reg;
  assign o_err_op_a  = err_a_reg;
  assign o_err_op_b  = err_b_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign o_err_valid   = 1'b0;
  assign o_err_op_a    = '0;
  assign o_err_op_b    = '0;
`endif

  assign o_ready     = (state_reg == IDLE);
  assign o_chk_valid = chk_valid_reg;
  assign o_add_ok    = add_ok_reg;
  assign o_mul_ok    = mul_ok_reg;
  assign o_pass_cnt  = pass_cnt_reg;
  assign o_fail_cnt  = fail_cnt_reg;
endmodule

// File: tb/tb_arith_checker.sv
// Scoreboard bench for arith_checker: a 16-bit-counter instance and a 2-bit-counter instance share one stimulus stream.
module tb_arith_checker;
  localparam int WIDTH = 8;
`ifdef ARITH_CHECKER_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_valid = 1'b0;
  logic [7:0]       i_op_a = '0, i_op_b = '0;
  logic [8:0]       i_add_result = '0;
  logic [15:0]      i_mul_result = '0;

  logic             o_ready, o_chk_valid, o_add_ok, o_mul_ok, o_err_valid;
  logic [15:0]      o_pass_cnt, o_fail_cnt;
  logic [7:0]       o_err_op_a, o_err_op_b;
  logic             s_ready, s_chk_valid, s_add_ok, s_mul_ok, s_err_valid;
  logic [1:0]       s_pass_cnt, s_fail_cnt;
  logic [7:0]       s_err_op_a, s_err_op_b;

  arith_checker #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_add_result(i_add_result), .i_mul_result(i_mul_result),
    .o_chk_valid(o_chk_valid), .o_add_ok(o_add_ok), .o_mul_ok(o_mul_ok),
    .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt),
    .o_err_valid(o_err_valid), .o_err_op_a(o_err_op_a), .o_err_op_b(o_err_op_b)
  );

  arith_checker #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(s_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_add_result(i_add_result), .i_mul_result(i_mul_result),
    .o_chk_valid(s_chk_valid), .o_add_ok(s_add_ok), .o_mul_ok(s_mul_ok),
    .o_pass_cnt(s_pass_cnt), .o_fail_cnt(s_fail_cnt),
    .o_err_valid(s_err_valid), .o_err_op_a(s_err_op_a), .o_err_op_b(s_err_op_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       add_ok;
    logic       mul_ok;
    int         acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;

  int          pass_exp = 0, fail_exp = 0, pass_sat_exp = 0, fail_sat_exp = 0;
  logic        err_v_exp = 1'b0;
  logic [7:0]  err_a_exp = '0, err_b_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    q.delete();
    pass_exp = 0; fail_exp = 0; pass_sat_exp = 0; fail_sat_exp = 0;
    err_v_exp = 1'b0; err_a_exp = '0; err_b_exp = '0;
  endtask

  // i_valid is held high across reset on purpose: it must be ignored.
  task automatic apply_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_op_a = 8'h12; i_op_b = 8'h34; i_add_result = 9'h046; i_mul_result = 16'h03A8;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] add,
                      input logic [15:0] mul, output int acc_cyc);
    exp_t e;
    logic [8:0]  ref_sum;
    logic [15:0] ref_prod;
    ref_sum  = {1'b0, a} + {1'b0, b};
    ref_prod = 16'(a) * 16'(b);
    i_valid = 1'b1;
    i_op_a = a; i_op_b = b; i_add_result = add; i_mul_result = mul;
    acc_cyc = -1;
    for (int n = 0; n < 64; n++) begin
      if (o_ready) begin
        @(posedge clk); #1;
        acc_cyc  = cyc;
        e.a = a; e.b = b;
        e.add_ok = (ref_sum == add);
        e.mul_ok = (ref_prod == mul);
        e.acc_cyc = acc_cyc;
        q.push_back(e);
        i_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pass"}, o_pass_cnt, pass_exp);
    check({tag, "_fail"}, o_fail_cnt, fail_exp);
    check({tag, "_sat_pass"}, s_pass_cnt, pass_sat_exp);
    check({tag, "_sat_fail"}, s_fail_cnt, fail_sat_exp);
  endtask

  // Scoreboard consumer.
  always @(posedge clk) begin
    #1;
    if (o_chk_valid) begin
      if (q.size() == 0) begin
        check("unexpected_chk", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.add_ok && e.mul_ok) begin
          if (pass_exp < 65535) pass_exp++;
          if (pass_sat_exp < 3) pass_sat_exp++;
        end else begin
          if (fail_exp < 65535) fail_exp++;
          if (fail_sat_exp < 3) fail_sat_exp++;
          if (ERR_EN && !err_v_exp) begin
            err_v_exp = 1'b1; err_a_exp = e.a; err_b_exp = e.b;
          end
        end
        $display("[TB] vec a=%02h b=%02h add_ok=%0d mul_ok=%0d pass=%0d fail=%0d",
                 e.a, e.b, o_add_ok, o_mul_ok, o_pass_cnt, o_fail_cnt);
        check("latency", cyc - e.acc_cyc, WIDTH);
        check("add_ok", o_add_ok, e.add_ok);
        check("mul_ok", o_mul_ok, e.mul_ok);
        check("sat_chk_valid", s_chk_valid, 1);
        check("sat_add_ok", s_add_ok, e.add_ok);
        check("sat_mul_ok", s_mul_ok, e.mul_ok);
        check_counts("cnt");
        check("err_valid", o_err_valid, err_v_exp);
        check("err_op_a", o_err_op_a, err_a_exp);
        check("err_op_b", o_err_op_b, err_b_exp);
        check("sat_err_valid", s_err_valid, err_v_exp);
        check("sat_err_op_a", s_err_op_a, err_a_exp);
        check("sat_err_op_b", s_err_op_b, err_b_exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    logic [7:0] ra, rb;

    apply_reset();
    check("rst_ready", o_ready, 1);
    check("rst_chk_valid", o_chk_valid, 0);
    check("rst_add_ok", o_add_ok, 0);
    check("rst_mul_ok", o_mul_ok, 0);
    check_counts("rst");
    check("rst_err_valid", o_err_valid, 0);
    check("rst_err_a", o_err_op_a, 0);
    check("rst_err_b", o_err_op_b, 0);
    check("rst_sat_ready", s_ready, 1);

    // Basic pass.
    send(8'h30, 8'h14, 9'h044, 16'h03C0, c1);
    drain();

    // Back-to-back: second vector accepted in the first one's check cycle.
    apply_reset();
    send(8'hFC, 8'h04, 9'h100, 16'h03F0, c1);
    send(8'hFF, 8'hFF, 9'h1FE, 16'hFE01, c2);
    check("b2b_accept_gap", c2 - c1, WIDTH + 1);
    drain();
    check("b2b_pass_cnt", o_pass_cnt, 2);

    // Error injection, then a second failure that must not overwrite the capture.
    apply_reset();
    send(8'h30, 8'h14, 9'h0FF, 16'h03C0, c1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_add_ok", o_add_ok, 0);
    check("hold_mul_ok", o_mul_ok, 1);
    check("hold_chk_valid", o_chk_valid, 0);
    send(8'h01, 8'h01, 9'h002, 16'h0002, c1);
    drain();
    check("err2_fail_cnt", o_fail_cnt, 2);

    // Held i_valid during MUL is not taken until the checker returns to IDLE.
    apply_reset();
    send(8'h00, 8'h5A, 9'h05A, 16'h0000, c1);
    check("busy_ready", o_ready, 0);
    send(8'h07, 8'h09, 9'h010, 16'h003F, c2);
    check("held_accept_gap", c2 - c1, WIDTH + 1);
    drain();

    // Reset three cycles into a multiply aborts it.
    apply_reset();
    send(8'h11, 8'h22, 9'h033, 16'h0242, c1);
    repeat (2) @(posedge clk);
    apply_reset();
    check("abort_ready", o_ready, 1);
    check("abort_chk_valid", o_chk_valid, 0);
    check_counts("abort");
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    check_counts("abort_late");

    // Random passing vectors; the 2-bit counter saturates at 3.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, {1'b0, ra} + {1'b0, rb}, 16'(ra) * 16'(rb), c1);
    end
    drain();
    check("sat_pass_final", s_pass_cnt, 3);
    check("wide_pass_final", o_pass_cnt, 5);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
